// File: rtl/arm_pkg.sv
// Shared ARM pipeline definitions: MEM-stage sequencer states, default SRAM
// timing/mapping constants and the EXE_CMD encodings emitted by decode.
package arm_pkg;

    // MEM-stage SRAM sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } sram_state_e;

    // Byte address mapped to SRAM word 0, and SRAM cycles per transfer
    localparam int unsigned DEF_BASE_ADDR   = 1024;
    localparam int unsigned DEF_WAIT_CYCLES = 4;

    // EXE_CMD encodings (ALU operation selected by the decoder)
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_CMP = 4'b0100;
    localparam logic [3:0] EXE_TST = 4'b0110;
    localparam logic [3:0] EXE_LDR = 4'b0010;  // address = Rn + offset
    localparam logic [3:0] EXE_STR = 4'b0010;

endpackage

// File: rtl/sram_wait_timer.sv
// Loadable down-counter with a zero flag; times the SRAM wait states.
module sram_wait_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    // Load has priority; decrement stops at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (dec && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/sram_controller.sv
// MEM-stage SRAM access sequencer: maps the ALU byte address onto the SRAM
// word address, drives the strobes for a fixed number of wait states and
// holds ready low so the pipeline freezes until the access completes.
// Optional: define SRAM_STALL_CNT_EN to add a saturating stall-cycle counter.
module sram_controller
    import arm_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int MEM_ADDR_W  = 16,
    parameter int BASE_ADDR   = DEF_BASE_ADDR,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_r_en,
    input  logic                  mem_w_en,
    input  logic [31:0]           addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata,
    output logic                  ready,
    output logic [MEM_ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0]     sram_wdata,
    input  logic [DATA_W-1:0]     sram_rdata,
    output logic                  sram_we_n,
    output logic                  sram_oe_n
`ifdef SRAM_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);

    localparam int TW = $clog2(WAIT_CYCLES + 1);

    sram_state_e           state_q, state_d;
    logic                  op_wr_q, op_wr_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic [MEM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0]     sram_wdata_q, sram_wdata_d;

    logic        req;
    logic        tmr_load, tmr_dec, tmr_zero;
    logic [31:0] addr_off;
    logic        unused_addr_bits;

    assign req = mem_r_en | mem_w_en;

    // Offset from the SRAM window; below-base addresses wrap naturally
    assign addr_off         = addr - 32'(BASE_ADDR);
    assign unused_addr_bits = ^{addr_off[31:MEM_ADDR_W+2], addr_off[1:0]};

    sram_wait_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (TW'(WAIT_CYCLES - 1)),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state: DONE always returns to IDLE, inputs there are stale
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req)      state_d = ST_ACCESS;
            ST_ACCESS: if (tmr_zero) state_d = ST_DONE;
            ST_DONE:                 state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Outputs: strobes decode from state so reset drops them immediately
    always_comb begin
        ready     = 1'b1;
        sram_we_n = 1'b1;
        sram_oe_n = 1'b1;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready    = ~req;
                tmr_load = req;
            end
            ST_ACCESS: begin
                ready     = 1'b0;
                sram_we_n = ~op_wr_q;
                sram_oe_n = op_wr_q;
                tmr_dec   = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath next values: capture request in IDLE, load result at end of read
    always_comb begin
        op_wr_d      = op_wr_q;
        rdata_d      = rdata_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        if (state_q == ST_IDLE && req) begin
            op_wr_d      = mem_w_en;  // write wins over a simultaneous read
            sram_addr_d  = addr_off[MEM_ADDR_W+1:2];
            sram_wdata_d = wdata;
        end
        if (state_q == ST_ACCESS && tmr_zero && !op_wr_q)
            rdata_d = sram_rdata;
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_wr_q      <= 1'b0;
            rdata_q      <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
        end else begin
            op_wr_q      <= op_wr_d;
            rdata_q      <= rdata_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
        end
    end

    assign rdata      = rdata_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;

`ifdef SRAM_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count frozen cycles, saturating at all-ones
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!ready && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // Stall counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
